// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK transmit scheduler.
// Build option: define FSK_TX_PARITY_EN to carry even parity in frame bit 8;
// otherwise bit 8 is a constant stop marker.
package fsk_pkg;

    localparam int FRAME_BITS = 9;
    localparam int BIT_CLKS   = 16;

    typedef logic [FRAME_BITS-1:0] fsk_frame_t;

    // Idle tone: all ones, sent whenever no data frame is on air.
    localparam fsk_frame_t IDLE_WORD = 9'h1FF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fsk_tx_state_t;

    // Build a 9-bit air frame from a payload byte; bit 0 is sent first.
    function automatic fsk_frame_t build_frame(input logic [7:0] data);
`ifdef FSK_TX_PARITY_EN
        return {^data, data};
`else
        return {1'b1, data};
`endif
    endfunction

endpackage

// File: rtl/fsk_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer; the pointer moves past the winner whenever a grant is taken.
module fsk_rr_arbiter #(
    parameter int N_REQ  = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic             found;

    // Search requesters starting at the pointer, wrapping around once.
    always_comb begin
        int j;
        j         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = enable;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Advance the pointer past the requester that just transferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fsk_tx_scheduler.sv
// FSK transmit scheduler: arbitrates N_REQ byte requesters into a one-frame
// holding buffer and presents frames to the 9-bit FSK modulator, changing
// mod_data only at the modulator's frame boundary. Owns the modulator reset
// so the local bit/frame counters stay in lockstep with the modulator's.
// Build option: FSK_TX_PARITY_EN (see fsk_pkg) selects the bit-8 content.
//
// Requester handshake: a byte moves when req_valid[i] & req_ready[i] are both
// high at a rising clk edge. req_ready is one-hot, may only be high while the
// holding buffer is empty and reset is low, and does not depend on req_data.
module fsk_tx_scheduler
    import fsk_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 8,
    parameter int BIT_CLKS = 16,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [FRAME_BITS-1:0]   mod_data,
    output logic                    mod_reset_n,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    frame_done,
    output logic                    dbg_state
);

    localparam int CNT_W  = $clog2(BIT_CLKS);
    localparam int FIDX_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FRAME_BITS - 1);

    fsk_tx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [FIDX_W-1:0] idx;
    logic             frame_b;

    fsk_frame_t       hold;
    logic             hold_full;
    logic [IDX_W-1:0] hold_id;

    logic             arb_en;
    logic [IDX_W-1:0] arb_idx;
    logic             xfer;

    // Modulator reset follows our reset one clock late.
    always_ff @(posedge clk) begin
        if (reset) begin
            mod_reset_n <= 1'b0;
        end else begin
            mod_reset_n <= 1'b1;
        end
    end

    // Mirror of the modulator's bit counter and frame bit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (mod_reset_n) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == FIDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Last clock of the frame: the modulator starts a new frame after this edge.
    assign frame_b = (cnt == CNT_LAST) && (idx == FIDX_LAST) && mod_reset_n;

    assign arb_en = ~hold_full & ~reset;
    assign xfer   = |req_ready;

    fsk_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (req_ready),
        .grant_idx (arb_idx)
    );

    // Holding buffer: filled by a transfer, drained onto the air at the boundary.
    // A transfer can only happen while empty, so fill and drain never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold      <= IDLE_WORD;
            hold_id   <= '0;
        end else begin
            if (frame_b && hold_full) begin
                hold_full <= 1'b0;
            end
            if (xfer) begin
                hold      <= build_frame(req_data[arb_idx*DATA_W +: DATA_W]);
                hold_id   <= arb_idx;
                hold_full <= 1'b1;
            end
        end
    end

    // Frame FSM: picks data or idle tone for the next frame at each boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mod_data <= IDLE_WORD;
            grant_id <= '0;
        end else if (frame_b) begin
            if (hold_full) begin
                state    <= ST_SEND;
                mod_data <= hold;
                grant_id <= hold_id;
            end else begin
                state    <= ST_IDLE;
                mod_data <= IDLE_WORD;
            end
        end
    end

    // A frame cut short by reset never reports completion.
    assign frame_done = frame_b && (state == ST_SEND) && !reset;
    assign busy       = (state == ST_SEND) || hold_full;
    assign dbg_state  = (state == ST_SEND);

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Self-checking bench for fsk_tx_scheduler (N_REQ=2).
module tb_fsk_tx_scheduler;

  localparam int FRAME_CLKS = 144;

  logic       clk;
  logic       reset;
  logic       val0, val1;
  logic [7:0] d0, d1;
  logic [1:0] req_valid;
  logic [15:0] req_data;
  logic [1:0] req_ready;
  logic [8:0] mod_data;
  logic       mod_reset_n;
  logic       busy;
  logic [0:0] grant_id;
  logic       frame_done;
  logic       dbg_state;

  assign req_valid = {val1, val0};
  assign req_data  = {d1, d0};

  fsk_tx_scheduler #(
    .N_REQ    (2),
    .DATA_W   (8),
    .BIT_CLKS (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .mod_data    (mod_data),
    .mod_reset_n (mod_reset_n),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_frame(input logic [7:0] d);
`ifdef FSK_TX_PARITY_EN
    return {^d, d};
`else
    return {1'b1, d};
`endif
  endfunction

  function automatic logic [1:0] rr_pick(input logic [1:0] v, input int p);
    logic [1:0] g;
    g = 2'b00;
    for (int i = 0; i < 2; i++) begin
      int j;
      j = (p + i) % 2;
      if (g == 2'b00 && v[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  // scoreboard: frames accepted, waiting to go on air
  logic [8:0] exp_q[$];
  logic [0:0] id_q[$];

  // model state; m_pos = clock position inside the frame, -1 while modulator held in reset
  int         m_pos = -2;
  int         m_ptr = 0;
  bit         m_hold_full = 0;
  bit         m_send = 0;
  logic [8:0] m_air_word = 9'h1FF;
  logic [0:0] m_air_id = 1'b0;
  bit         chk_out = 0;
  int         m_b_count = 0;

  always @(negedge clk) begin
    logic       b;
    logic [1:0] exp_rdy;
    int         g;
    if (m_pos == -1) begin
      check("mod_reset_n_low", 16'(mod_reset_n), 16'd0);
      check("rst_mod_data", 16'(mod_data), 16'h1FF);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_grant_id", 16'(grant_id), 16'd0);
    end
    if (m_pos == 0) check("mod_reset_n_high", 16'(mod_reset_n), 16'd1);
    if (chk_out) begin
      check("mod_data_at_frame", 16'(mod_data), 16'(m_air_word));
      if (m_send) check("grant_id", 16'(grant_id), 16'(m_air_id));
      check("state", 16'(dbg_state), 16'(m_send));
      chk_out = 0;
    end
    if (m_pos == 72) begin
      check("mod_data_mid", 16'(mod_data), 16'(m_air_word));
      check("busy_mid", 16'(busy), 16'(m_send | m_hold_full));
    end
    b = (m_pos == FRAME_CLKS - 1);
    if (reset) begin
      check("ready_in_reset", 16'(req_ready), 16'd0);
      if (frame_done) check("frame_done_in_reset", 16'(frame_done), 16'd0);
      exp_q.delete();
      id_q.delete();
      m_pos = -1;
      m_ptr = 0;
      m_hold_full = 0;
      m_send = 0;
      m_air_word = 9'h1FF;
      m_air_id = 1'b0;
      chk_out = 0;
    end else begin
      exp_rdy = m_hold_full ? 2'b00 : rr_pick(req_valid, m_ptr);
      if (req_valid != 2'b00 || req_ready != 2'b00)
        check("req_ready", 16'(req_ready), 16'(exp_rdy));
      if (b || frame_done)
        check("frame_done", 16'(frame_done), 16'(b && m_send));
      if (b) begin
        m_b_count++;
        if (m_hold_full) begin
          m_air_word = exp_q.pop_front();
          m_air_id = id_q.pop_front();
          m_send = 1;
          m_hold_full = 0;
        end else begin
          m_air_word = 9'h1FF;
          m_send = 0;
        end
        chk_out = 1;
      end
      if (exp_rdy != 2'b00) begin
        g = exp_rdy[1] ? 1 : 0;
        exp_q.push_back(exp_frame(g == 1 ? d1 : d0));
        id_q.push_back(1'(g));
        m_hold_full = 1;
        m_ptr = (g + 1) % 2;
      end
      if (m_pos >= 0) m_pos = (m_pos == FRAME_CLKS - 1) ? 0 : m_pos + 1;
      else if (m_pos == -1) m_pos = 0;
    end
  end

  // driver tasks
  task automatic send_byte(input int i, input logic [7:0] d);
    bit got;
    got = 0;
    if (i == 0) begin val0 = 1'b1; d0 = d; end
    else begin val1 = 1'b1; d1 = d; end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1; break; end
    end
    @(posedge clk); #1;
    if (i == 0) val0 = 1'b0; else val1 = 1'b0;
    if (!got) check("accept_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_b(input int n);
    int target;
    bit ok;
    target = m_b_count + n;
    ok = 0;
    for (int c = 0; c < FRAME_CLKS * n + 300; c++) begin
      @(posedge clk);
      if (m_b_count >= target) begin ok = 1; break; end
    end
    if (!ok) check("wait_b_timeout", 16'd0, 16'd1);
    #1;
  endtask

  task automatic wait_send_pos(input int p);
    bit ok;
    ok = 0;
    for (int c = 0; c < 2 * FRAME_CLKS + 10; c++) begin
      @(posedge clk);
      if (m_send && m_pos == p) begin ok = 1; break; end
    end
    if (!ok) check("wait_pos_timeout", 16'd0, 16'd1);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    val0 = 1'b0; val1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00;

    // 1: reset for 3 clocks, release, idle tone with no requests
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (FRAME_CLKS + 20) @(posedge clk);
    #1;

    // 2: single byte from requester 0
    send_byte(0, 8'hA5);
    wait_b(3);

    // 3 and 4: both requesters continuously valid; grants alternate, frames
    // back to back, bytes offered at a boundary with hold full wait one clock
    fork
      begin
        for (int k = 0; k < 4; k++) send_byte(0, 8'h01 + 8'(k * 16));
      end
      begin
        for (int k = 0; k < 4; k++) send_byte(1, 8'h02 + 8'(k * 16));
      end
    join
    wait_b(3);

    // random bytes with random requester choice
    for (int k = 0; k < 3; k++) begin
      send_byte(int'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    wait_b(3);

    // 5: reset mid-frame with a byte on air and another held
    send_byte(0, 8'h3C);
    wait_b(1);
    send_byte(1, 8'h5A);
    wait_send_pos(70);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_byte(1, 8'hC3);
    wait_b(3);

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
